// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks in-flight long-latency writers (loads, multiplies) in a small
//   scoreboard of countdown slots. It stalls the ID instruction on a source
//   match against a pending destination, or when a writer finds no free slot.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-low reset
//   id_valid_i     ID holds a real instruction
//   id_rs_addr_i   ID source 1 address       id_rs_used_i  source 1 is read
//   id_rt_addr_i   ID source 2 address       id_rt_used_i  source 2 is read
//   id_rd_addr_i   ID destination address
//   id_kind_i      00 ALU/none, 01 load, 10 multiply, 11 treated as 00
//   flush_i        ID instruction squashed this cycle
//   select_o       1 = insert bubble into ID_EX
//   PC_write_o     0 = hold PC
//   IF_ID_write_o  0 = hold IF_ID
//   full_o         every slot is valid
//   stall_cnt_o    saturating count of stall cycles
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int ENTRIES  = 4,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [1:0]        id_kind_i,
  input  logic              flush_i,
  output logic              select_o,
  output logic              PC_write_o,
  output logic              IF_ID_write_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [2:0] LOAD_CNT = 3'(LOAD_LAT);
  localparam logic [2:0] MUL_CNT  = 3'(MUL_LAT);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [REG_AW-1:0]  rd_q  [ENTRIES];
  logic [REG_AW-1:0]  rd_d  [ENTRIES];
  logic [2:0]         cnt_q [ENTRIES];
  logic [2:0]         cnt_d [ENTRIES];
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               id_live;
  logic               is_load, is_mul, is_wr;
  logic               haz, shaz, stall, issue, full;
  logic [ENTRIES-1:0] alloc_oh;
  logic               found;

  always_comb begin
    id_live = id_valid_i & ~flush_i;
    is_load = (id_kind_i == 2'b01);
    is_mul  = (id_kind_i == 2'b10);
    is_wr   = is_load | is_mul;
    full    = &valid_q;

    // x0 never matches: a zero source address is ignored outright.
    haz = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] &&
          ((rd_q[i] == id_rs_addr_i && id_rs_used_i && |id_rs_addr_i) ||
           (rd_q[i] == id_rt_addr_i && id_rt_used_i && |id_rt_addr_i)))
        haz = 1'b1;
    end
    haz   = haz & id_live;
    shaz  = id_live & is_wr & (|id_rd_addr_i) & full;
    stall = haz | shaz;
    issue = id_live & ~stall & is_wr & (|id_rd_addr_i);

    // Lowest free slot, judged on cycle-start state, so a slot expiring at
    // this edge cannot be reused until the following cycle.
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!valid_q[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end

    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      rd_d[i]    = rd_q[i];
      cnt_d[i]   = cnt_q[i];
      if (issue && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = id_rd_addr_i;
        cnt_d[i]   = is_load ? LOAD_CNT : MUL_CNT;
      end else if (valid_q[i]) begin
        if (cnt_q[i] == 3'd1)
          valid_d[i] = 1'b0;
        cnt_d[i] = cnt_q[i] - 3'd1;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload fields are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++) begin
      rd_q[i]  <= rd_d[i];
      cnt_q[i] <= cnt_d[i];
    end
  end

  assign select_o      = rst_i & stall;
  assign PC_write_o    = ~(rst_i & stall);
  assign IF_ID_write_o = ~(rst_i & stall);
  assign full_o        = full;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_i, id_valid_i, id_rs_used_i, id_rt_used_i, flush_i;
  logic [4:0] id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
  logic [1:0] id_kind_i;

  logic       sel0, pcw0, ifw0, full0;
  logic       sel1, pcw1, ifw1, full1;
  logic [15:0] cnt0;
  logic [5:0]  cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance 0: default parameters. Instance 1: longer latencies and a
  // narrow stall counter so saturation is reachable quickly.
  hazard_scoreboard u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_addr_i(id_rd_addr_i), .id_kind_i(id_kind_i), .flush_i(flush_i),
    .select_o(sel0), .PC_write_o(pcw0), .IF_ID_write_o(ifw0),
    .full_o(full0), .stall_cnt_o(cnt0)
  );

  hazard_scoreboard #(.REG_AW(5), .ENTRIES(4), .LOAD_LAT(2), .MUL_LAT(7), .CNT_W(6)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_addr_i(id_rd_addr_i), .id_kind_i(id_kind_i), .flush_i(flush_i),
    .select_o(sel1), .PC_write_o(pcw1), .IF_ID_write_o(ifw1),
    .full_o(full1), .stall_cnt_o(cnt1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each slot remembers the last cycle it is still pending.
  // A writer decided in cycle c occupies its slot for cycles c+1 .. c+lat.
  int         mc = 0;
  int         m_until [2][4];
  logic [4:0] m_rd    [2][4];
  int         m_cnt   [2];

  function automatic int lat_of(input int j, input logic [1:0] k);
    if (j == 0) return (k == 2'b01) ? 1 : 3;
    return (k == 2'b01) ? 2 : 7;
  endfunction

  function automatic int cmax_of(input int j);
    return (j == 0) ? 65535 : 63;
  endfunction

  initial begin
    for (int j = 0; j < 2; j++) begin
      m_cnt[j] = 0;
      for (int i = 0; i < 4; i++) begin
        m_until[j][i] = -1;
        m_rd[j][i]    = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic fullm, hz, live, wr, st, iss, done;
    int   a_sel, a_pcw, a_ifw, a_full, a_cnt;
    for (int j = 0; j < 2; j++) begin
      live  = id_valid_i & ~flush_i;
      wr    = (id_kind_i == 2'b01) || (id_kind_i == 2'b10);
      fullm = 1'b1;
      hz    = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_until[j][i] < mc) fullm = 1'b0;
        else if ((id_rs_used_i && id_rs_addr_i != 0 && id_rs_addr_i == m_rd[j][i]) ||
                 (id_rt_used_i && id_rt_addr_i != 0 && id_rt_addr_i == m_rd[j][i]))
          hz = 1'b1;
      end
      st  = live & (hz | (wr & (id_rd_addr_i != 0) & fullm));
      iss = live & ~st & wr & (id_rd_addr_i != 0);

      a_sel  = (j == 0) ? int'(sel0)  : int'(sel1);
      a_pcw  = (j == 0) ? int'(pcw0)  : int'(pcw1);
      a_ifw  = (j == 0) ? int'(ifw0)  : int'(ifw1);
      a_full = (j == 0) ? int'(full0) : int'(full1);
      a_cnt  = (j == 0) ? int'(cnt0)  : int'(cnt1);
      chk($sformatf("model_select[%0d]", j), a_sel, (rst_i && st) ? 1 : 0);
      chk($sformatf("model_pcw[%0d]", j), a_pcw, (rst_i && st) ? 0 : 1);
      chk($sformatf("model_ifid[%0d]", j), a_ifw, (rst_i && st) ? 0 : 1);
      chk($sformatf("model_full[%0d]", j), a_full, int'(fullm));
      chk($sformatf("model_cnt[%0d]", j), a_cnt, m_cnt[j]);

      if (!rst_i) begin
        m_cnt[j] = 0;
        for (int i = 0; i < 4; i++) m_until[j][i] = -1;
      end else begin
        if (st && m_cnt[j] < cmax_of(j)) m_cnt[j]++;
        if (iss) begin
          done = 1'b0;
          for (int i = 0; i < 4; i++) begin
            if (!done && m_until[j][i] < mc) begin
              m_until[j][i] = mc + lat_of(j, id_kind_i);
              m_rd[j][i]    = id_rd_addr_i;
              done          = 1'b1;
            end
          end
        end
      end
    end
    mc++;
  end

  // Apply inputs just after a rising edge; return 2 time units later so the
  // caller can sample combinational outputs for this cycle.
  task automatic drv(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic rsu, input logic rtu, input logic [4:0] rd,
                     input logic [1:0] k, input logic fl);
    @(posedge clk);
    #1;
    rst_i = r; id_valid_i = v; id_rs_addr_i = rs; id_rt_addr_i = rt;
    id_rs_used_i = rsu; id_rt_used_i = rtu; id_rd_addr_i = rd;
    id_kind_i = k; flush_i = fl;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  initial begin
    rst_i = 0; id_valid_i = 0; id_rs_addr_i = 0; id_rt_addr_i = 0;
    id_rs_used_i = 0; id_rt_used_i = 0; id_rd_addr_i = 0; id_kind_i = 0; flush_i = 0;

    drv(0, 1, 5, 0, 1, 0, 5, 2'b01, 0);
    drv(0, 1, 5, 0, 1, 0, 5, 2'b01, 0);
    chk("rst_forced_select", sel0, 0);
    chk("rst_forced_pcw", pcw0, 1);
    idle(1);
    chk("reset_full", full0, 0);
    chk("reset_cnt", cnt0, 0);

    // Classic load-use: one bubble on instance 0.
    drv(1, 1, 0, 0, 0, 0, 5, 2'b01, 0);
    chk("load_issue_nostall", sel0, 0);
    drv(1, 1, 5, 0, 1, 0, 0, 2'b00, 0);
    chk("loaduse_select", sel0, 1);
    chk("loaduse_pcw", pcw0, 0);
    chk("loaduse_ifid", ifw0, 0);
    drv(1, 1, 5, 0, 1, 0, 0, 2'b00, 0);
    chk("loaduse_release_sel", sel0, 0);
    chk("loaduse_release_pcw", pcw0, 1);
    chk("loaduse_release_ifid", ifw0, 1);
    chk("loaduse_cnt", cnt0, 1);
    drv(1, 1, 5, 0, 1, 0, 0, 2'b00, 0);
    idle(10);

    // Multiply then dependent rt read: three bubbles.
    drv(1, 1, 0, 0, 0, 0, 7, 2'b10, 0);
    for (int k = 0; k < 3; k++) begin
      drv(1, 1, 0, 7, 0, 1, 0, 2'b00, 0);
      chk("mul_dep_stall", sel0, 1);
    end
    drv(1, 1, 0, 7, 0, 1, 0, 2'b00, 0);
    chk("mul_dep_release", sel0, 0);
    chk("mul_dep_cnt", cnt0, 4);
    idle(10);
    drv(1, 1, 0, 0, 0, 0, 7, 2'b10, 0);
    drv(1, 1, 0, 7, 0, 0, 0, 2'b00, 0);
    chk("mul_rt_unused", sel0, 0);
    idle(10);
    drv(1, 1, 0, 0, 0, 0, 0, 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 2'b10, 0);
    chk("mul_rd0_not_full", full0, 0);
    idle(10);

    // Structural full on instance 1 (MUL_LAT=7).
    for (int k = 1; k <= 4; k++) drv(1, 1, 0, 0, 0, 0, 5'(k), 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 9, 2'b10, 0);
    chk("full_flag", full1, 1);
    chk("full_stall", sel1, 1);
    chk("full_inst0_free", sel0, 0);
    for (int k = 0; k < 3; k++) drv(1, 1, 0, 0, 0, 0, 9, 2'b10, 0);
    chk("full_stall_last", sel1, 1);
    drv(1, 1, 0, 0, 0, 0, 9, 2'b10, 0);
    chk("full_release", sel1, 0);
    chk("full_release_pcw", pcw1, 1);
    idle(10);

    // Flush suppresses stall; pending slot keeps its schedule.
    drv(1, 1, 0, 0, 0, 0, 7, 2'b10, 0);
    drv(1, 1, 7, 0, 1, 0, 8, 2'b10, 1);
    chk("flush_select", sel0, 0);
    chk("flush_pcw", pcw0, 1);
    drv(1, 1, 7, 0, 1, 0, 0, 2'b00, 0);
    chk("flush_after_stall_a", sel0, 1);
    drv(1, 1, 7, 0, 1, 0, 0, 2'b00, 0);
    chk("flush_after_stall_b", sel0, 1);
    drv(1, 1, 7, 0, 1, 0, 0, 2'b00, 0);
    chk("flush_after_release", sel0, 0);
    idle(10);

    // Two loads to rd=6 back to back, instance 1 (LOAD_LAT=2).
    drv(1, 1, 0, 0, 0, 0, 6, 2'b01, 0);
    drv(1, 1, 0, 0, 0, 0, 6, 2'b01, 0);
    drv(1, 1, 6, 0, 1, 0, 0, 2'b00, 0);
    chk("dual_load_stall_a", sel1, 1);
    drv(1, 1, 6, 0, 1, 0, 0, 2'b00, 0);
    chk("dual_load_stall_b", sel1, 1);
    drv(1, 1, 6, 0, 1, 0, 0, 2'b00, 0);
    chk("dual_load_release", sel1, 0);
    idle(10);

    // Reset with three slots pending.
    drv(1, 1, 0, 0, 0, 0, 10, 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 11, 2'b10, 0);
    drv(1, 1, 0, 0, 0, 0, 12, 2'b10, 0);
    drv(0, 1, 10, 0, 1, 0, 0, 2'b00, 0);
    chk("midrst_forced_sel", sel0, 0);
    drv(1, 1, 10, 0, 1, 0, 0, 2'b00, 0);
    chk("midrst_no_stall", sel0, 0);
    chk("midrst_full", full0, 0);
    chk("midrst_cnt", cnt0, 0);

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom % 200) != 0, ($urandom % 8) != 0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), ($urandom % 10) == 0);
    end

    // Dependent multiply chain: mostly stall cycles; instance 1 saturates.
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int n = 0; n < 300; n++) drv(1, 1, 3, 0, 1, 0, 3, 2'b10, 0);
    chk("sat_cnt1", cnt1, 63);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
